// File: rtl/instr_result_checker.sv
// Readback checker for the instruction register: walks a window of entries,
// recomputes each result from opcode/operands and tallies pass/fail/skip.
package instr_register_pkg;
    typedef logic signed [31:0] operand_t;
    typedef enum logic [2:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef logic [4:0] address_t;
    typedef struct packed {
        opcode_t            opc;
        operand_t           op_a;
        operand_t           op_b;
        logic signed [63:0] result;
    } instruction_t;
endpackage

module instr_result_checker
    import instr_register_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  address_t           first_addr,
    input  logic [5:0]         count,
    input  instruction_t       instruction_word,
    output address_t           read_pointer,
    output logic               busy,
    output logic               done,
    output logic [5:0]         pass_count,
    output logic [5:0]         fail_count,
    output logic [5:0]         skip_count,
    output logic               err_valid,
    output address_t           err_addr,
    output logic signed [63:0] err_expected,
    output logic signed [63:0] err_actual
);

    typedef enum logic [1:0] {IDLE, FETCH, CHECK, DONE} state_t;

    state_t             state, next_state;
    instruction_t       iw_q;
    address_t           addr_q;
    logic [5:0]         remaining;
    logic [5:0]         eff_count;
    address_t           next_pointer;
    logic signed [63:0] a64, b64, divisor, expected;
    logic               skip;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   next_state = CHECK;
            CHECK:   next_state = (remaining == 6'd1) ? DONE : FETCH;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        eff_count    = (count == 6'd0 || count > 6'd32) ? 6'd32 : count;
        next_pointer = (read_pointer == address_t'(DEPTH - 1)) ? '0 : read_pointer + 5'd1;
    end

    // Divisor is forced non-zero so the skipped DIV/MOD cases never produce X.
    always_comb begin
        a64      = {{32{iw_q.op_a[31]}}, iw_q.op_a};
        b64      = {{32{iw_q.op_b[31]}}, iw_q.op_b};
        divisor  = (iw_q.op_b == '0) ? 64'sd1 : b64;
        skip     = (iw_q.opc == DIV || iw_q.opc == MOD) && (iw_q.op_b == '0);
        expected = '0;
        case (iw_q.opc)
            PASSA:   expected = a64;
            PASSB:   expected = b64;
            ADD:     expected = a64 + b64;
            SUB:     expected = a64 - b64;
            MULT:    expected = a64 * b64;
            DIV:     expected = a64 / divisor;
            MOD:     expected = a64 % divisor;
            default: expected = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass_count   <= '0;
            fail_count   <= '0;
            skip_count   <= '0;
            err_valid    <= 1'b0;
            err_addr     <= '0;
            err_expected <= '0;
            err_actual   <= '0;
            iw_q         <= '0;
            addr_q       <= '0;
            remaining    <= '0;
        end else begin
            busy      <= (next_state != IDLE);
            done      <= (next_state == DONE);
            err_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        read_pointer <= first_addr;
                        remaining    <= eff_count;
                        pass_count   <= '0;
                        fail_count   <= '0;
                        skip_count   <= '0;
                    end
                end
                FETCH: begin
                    iw_q   <= instruction_word;
                    addr_q <= read_pointer;
                end
                CHECK: begin
                    if (skip) begin
                        if (skip_count != 6'd32) skip_count <= skip_count + 6'd1;
                    end else if (expected == iw_q.result) begin
                        if (pass_count != 6'd32) pass_count <= pass_count + 6'd1;
                    end else begin
                        if (fail_count != 6'd32) fail_count <= fail_count + 6'd1;
                        err_valid    <= 1'b1;
                        err_addr     <= addr_q;
                        err_expected <= expected;
                        err_actual   <= iw_q.result;
                    end
                    if (remaining != 6'd1) begin
                        read_pointer <= next_pointer;
                        remaining    <= remaining - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instr_result_checker.md
# instr_result_checker

Self-checking readback stage downstream of the instruction register. On `start`, it walks a window of register entries through the register's read port (`read_pointer` → `instruction_word`). For each entry it recomputes the expected result from the stored opcode and operands and compares it with the stored result. It reports per-entry mismatches and end-of-run pass/fail/skip totals, so a bench or on-chip monitor can confirm register contents without a software model.

## Interface
Types come from `instr_register_pkg`:
- `operand_t`: signed 32-bit
- `opcode_t`: ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
- `address_t`: 5-bit
- `instruction_t`: `{opc, op_a, op_b, result}`, where `result` is signed 64-bit

Parameters:
- `DEPTH`, default 32: number of register entries; address wraps modulo `DEPTH`.

Ports:
- `clk`  in  1: clock.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: run request; sampled only in IDLE.
- `first_addr`  in  address_t: first entry to check.
- `count`  in  6: number of entries; 0 or >32 means 32.
- `instruction_word`  in  instruction_t: combinational register read data for `read_pointer`.
- `read_pointer`  out  address_t: registered read address to the register.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse at end of run.
- `pass_count`  out  6: entries compared equal.
- `fail_count`  out  6: entries compared unequal.
- `skip_count`  out  6: DIV/MOD entries with `op_b == 0`.
- `err_valid`  out  1: one-cycle pulse per mismatch.
- `err_addr`  out  address_t: address of the mismatching entry.
- `err_expected`  out  signed 64: recomputed result.
- `err_actual`  out  signed 64: stored result.

## Operation
- FSM states: IDLE, FETCH, CHECK, DONE.
- **IDLE**
  - `start` = 1 → FETCH.
  - On that edge: load `read_pointer` from `first_addr`; load `remaining` from effective count; clear pass/fail/skip counters.
- **FETCH**
  - Register `instruction_word` into `iw_q` and `read_pointer` into `addr_q`.
  - → CHECK.
- **CHECK**
  - Compute expected from `iw_q` in signed 64-bit arithmetic, with operands sign-extended:
    - PASSA: `op_a`
    - PASSB: `op_b`
    - ADD: `a+b`
    - SUB: `a-b`
    - MULT: `a*b` (full 64-bit product)
    - DIV: `a/b`, truncating toward zero
    - MOD: `a%b`, sign of `a`
    - ZERO or any other encoding: 0
  - DIV/MOD with `op_b == 0`: increment `skip_count`; no compare, no `err_valid`.
  - Equal: increment `pass_count`.
  - Unequal: increment `fail_count`; on the same edge, register `err_valid` = 1, `err_addr` = `addr_q`, `err_expected`, `err_actual`.
  - If `remaining == 1` → DONE.
  - Otherwise: `read_pointer` +1 (DEPTH−1 wraps to 0), `remaining` −1, → FETCH.
- **DONE**
  - `done` = 1 for this cycle only.
  - → IDLE.
- Counters saturate at 32 (cannot exceed 32 by construction).
- Counters hold their values after DONE until the next accepted `start`.
- `start` while busy: ignored, no queuing.
- `first_addr` and `count` are sampled only on the accepting edge; later changes have no effect on a run.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - `read_pointer` 0
  - `busy` 0, `done` 0, `err_valid` 0
  - all counters 0
  - `err_addr` 0, `err_expected` 0, `err_actual` 0
- Run timing, with `start` sampled at edge 0:
  - FETCH in cycles 1, 3, 5, …; CHECK in cycles 2, 4, …
  - `done` high in cycle 2N+1.
  - `busy` high in cycles 1 through 2N+1.
- Throughput: one entry per 2 cycles.
- `read_pointer` is stable for the whole FETCH cycle; `instruction_word` must settle within that cycle (it is a combinational read).
- `err_valid` is high in the cycle following the mismatching CHECK, i.e. in the next FETCH or DONE. `err_*` fields hold until the next mismatch or reset.
- Final counter values are valid in the DONE cycle.
- Register writes during a run are not blocked. An entry written before its FETCH cycle is checked with the new contents.
- `reset_n` low at any point, including mid-run: immediately IDLE with all reset values; a pending `done` is not issued.

## Test plan
- Load entry 0 with ADD a=5 b=−7 result=−2 and entry 1 with MULT a=100000 b=300000 result=30000000000; start `first_addr`=0 `count`=2 → `pass_count`=2, `fail_count`=0, `done` in cycle 5, `read_pointer` sequence 0, 1.
- Entry 3 with SUB a=10 b=3 but stored result 6; start `first_addr`=3 `count`=1 → `err_valid` pulse with `err_addr`=3, `err_expected`=7, `err_actual`=6; `fail_count`=1.
- `first_addr`=30 `count`=4 → `read_pointer` 30, 31, 0, 1 (wrap); `done` in cycle 9.
- DIV a=−7 b=2 result=−3, MOD a=−7 b=2 result=−1, and DIV b=0 → pass=2, skip=1, fail=0.
- `count`=0 → 32 entries checked, `done` in cycle 65; a second `start` pulsed at cycle 10 is ignored.
- `reset_n` low at cycle 6 of an 8-entry run → all outputs at reset values at once, no `done`; a new `start` after release runs normally with counters starting from 0.
